// File: rtl/jedro_1_defines.sv
// Shared jedro_1 definitions: control FSM states, trap cause codes,
// default redirect addresses and the control flag decode helper.
package jedro_1_defines;

  // Control FSM states; encodings 6 and 7 are unreachable.
  typedef enum logic [2:0] {
    CTRL_BOOT     = 3'd0,
    CTRL_FLUSH    = 3'd1,
    CTRL_RUN      = 3'd2,
    CTRL_JUMP     = 3'd3,
    CTRL_LSU_WAIT = 3'd4,
    CTRL_TRAP     = 3'd5
  } ctrl_state_e;

  localparam logic [3:0] MCAUSE_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] MCAUSE_ILLEGAL_INSTR  = 4'd2;
  localparam logic [3:0] MCAUSE_LOAD_FAULT     = 4'd5;

  localparam logic [31:0] CTRL_BOOT_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] CTRL_TRAP_VEC_DEFAULT  = 32'h0000_0100;

  // Pipeline/IFU control flags driven by the control FSM.
  typedef struct packed {
    logic get_next;
    logic jmp;
    logic stall;
    logic flush;
    logic trap;
  } ctrl_flags_t;

  localparam ctrl_flags_t CTRL_FLAGS_RESET = '{
    get_next: 1'b0, jmp: 1'b0, stall: 1'b1, flush: 1'b1, trap: 1'b0
  };

  // Moore decode of the control flags from a state.
  function automatic ctrl_flags_t ctrl_decode(input ctrl_state_e s);
    ctrl_flags_t f;
    f.get_next = (s == CTRL_RUN) || (s == CTRL_FLUSH);
    f.jmp      = (s == CTRL_BOOT) || (s == CTRL_JUMP) || (s == CTRL_TRAP);
    f.stall    = (s != CTRL_RUN);
    f.flush    = (s == CTRL_BOOT) || (s == CTRL_JUMP) || (s == CTRL_TRAP) ||
                 (s == CTRL_FLUSH);
    f.trap     = (s == CTRL_TRAP);
    return f;
  endfunction

endpackage

// File: rtl/jedro_1_ctrl.sv
// jedro_1 central control FSM: sequences IFU redirects (boot, jump, trap),
// flushes fetched instructions after redirects, stalls on LSU activity and
// captures trap PC/cause.
// Ports:
//   clk_i, rstn_i            clock, synchronous active-low reset
//   instr_pc_i               PC of instruction in decode
//   jmp_req_i, jmp_addr_i    resolved taken jump and its target
//   illegal_instr_i          decoder illegal-instruction flag
//   lsu_new_ctrl_i           load/store issued this cycle
//   lsu_busy_i, lsu_err_i    LSU status
//   ifu_get_next_instr_o     IFU advance
//   ifu_jmp_instr_o          IFU redirect strobe
//   ifu_jmp_address_o        redirect target
//   stall_o, flush_o         pipeline freeze / bubble
//   trap_o, mepc_o, mcause_o trap strobe and captured trap info
module jedro_1_ctrl
  import jedro_1_defines::*;
#(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]  BOOT_ADDR    = DATA_WIDTH'(CTRL_BOOT_ADDR_DEFAULT),
  parameter logic [DATA_WIDTH-1:0]  TRAP_VEC     = DATA_WIDTH'(CTRL_TRAP_VEC_DEFAULT),
  parameter int unsigned            FLUSH_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] instr_pc_i,
  input  logic                  jmp_req_i,
  input  logic [DATA_WIDTH-1:0] jmp_addr_i,
  input  logic                  illegal_instr_i,
  input  logic                  lsu_new_ctrl_i,
  input  logic                  lsu_busy_i,
  input  logic                  lsu_err_i,
  output logic                  ifu_get_next_instr_o,
  output logic                  ifu_jmp_instr_o,
  output logic [DATA_WIDTH-1:0] ifu_jmp_address_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  trap_o,
  output logic [DATA_WIDTH-1:0] mepc_o,
  output logic [3:0]            mcause_o
);

  localparam int unsigned      CNT_W      = 4;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  boot_pend_q, boot_pend_d;
  ctrl_flags_t           flags_q, flags_d;
  logic [DATA_WIDTH-1:0] jmp_addr_q, jmp_addr_d;
  logic [DATA_WIDTH-1:0] mepc_q, mepc_d;
  logic [3:0]            mcause_q, mcause_d;
  logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;

  // Next-state, capture and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    boot_pend_d = boot_pend_q;
    jmp_addr_d  = jmp_addr_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    pend_pc_d   = pend_pc_q;

    unique case (state_q)
      // Held here through reset; boot_pend_q keeps the first post-reset
      // cycle in BOOT so the redirect strobe is visible for one cycle.
      CTRL_BOOT: begin
        if (boot_pend_q) begin
          boot_pend_d = 1'b0;
        end else begin
          state_d = CTRL_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      CTRL_JUMP, CTRL_TRAP: begin
        state_d = CTRL_FLUSH;
        cnt_d   = FLUSH_LOAD;
      end
      CTRL_FLUSH: begin
        if (cnt_q == '0) state_d = CTRL_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CTRL_RUN: begin
        if (illegal_instr_i) begin
          state_d  = CTRL_TRAP;
          mepc_d   = instr_pc_i;
          mcause_d = MCAUSE_ILLEGAL_INSTR;
        end else if (jmp_req_i && (jmp_addr_i[1:0] != 2'b00)) begin
          state_d  = CTRL_TRAP;
          mepc_d   = instr_pc_i;
          mcause_d = MCAUSE_INSTR_MISALIGN;
        end else if (jmp_req_i) begin
          state_d    = CTRL_JUMP;
          jmp_addr_d = jmp_addr_i;
        end else if (lsu_new_ctrl_i) begin
          state_d   = CTRL_LSU_WAIT;
          pend_pc_d = instr_pc_i;
        end
      end
      CTRL_LSU_WAIT: begin
        if (lsu_err_i) begin
          state_d  = CTRL_TRAP;
          mepc_d   = pend_pc_q;
          mcause_d = MCAUSE_LOAD_FAULT;
        end else if (!lsu_busy_i) begin
          state_d = CTRL_RUN;
        end
      end
      default: state_d = CTRL_BOOT;
    endcase

    // Redirect target follows the state being entered.
    if (state_d == CTRL_BOOT) jmp_addr_d = BOOT_ADDR;
    if (state_d == CTRL_TRAP) jmp_addr_d = TRAP_VEC;

    flags_d = ctrl_decode(state_d);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= CTRL_BOOT;
      cnt_q       <= '0;
      boot_pend_q <= 1'b1;
      flags_q     <= CTRL_FLAGS_RESET;
      jmp_addr_q  <= BOOT_ADDR;
      mepc_q      <= '0;
      mcause_q    <= '0;
      pend_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      boot_pend_q <= boot_pend_d;
      flags_q     <= flags_d;
      jmp_addr_q  <= jmp_addr_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      pend_pc_q   <= pend_pc_d;
    end
  end

  assign ifu_get_next_instr_o = flags_q.get_next;
  assign ifu_jmp_instr_o      = flags_q.jmp;
  assign stall_o              = flags_q.stall;
  assign flush_o              = flags_q.flush;
  assign trap_o               = flags_q.trap;
  assign ifu_jmp_address_o    = jmp_addr_q;
  assign mepc_o               = mepc_q;
  assign mcause_o             = mcause_q;

endmodule

// File: tb/tb_jedro_1_ctrl.sv
// Directed-vector bench for jedro_1_ctrl.
module tb_jedro_1_ctrl;

  logic        clk;
  logic        rstn;
  logic [31:0] instr_pc;
  logic        jmp_req;
  logic [31:0] jmp_addr;
  logic        illegal_instr;
  logic        lsu_new_ctrl;
  logic        lsu_busy;
  logic        lsu_err;
  logic        get_next;
  logic        jmp_instr;
  logic [31:0] jmp_address;
  logic        stall;
  logic        flush;
  logic        trap;
  logic [31:0] mepc;
  logic [3:0]  mcause;
  logic [4:0]  flags;

  int n_vec = 0;
  int n_err = 0;

  // flags = {get_next, jmp, stall, flush, trap}
  localparam logic [4:0] F_RST   = 5'b00110;
  localparam logic [4:0] F_REDIR = 5'b01110;
  localparam logic [4:0] F_TRAP  = 5'b01111;
  localparam logic [4:0] F_FLUSH = 5'b10110;
  localparam logic [4:0] F_RUN   = 5'b10000;
  localparam logic [4:0] F_LSU   = 5'b00100;

  jedro_1_ctrl dut (
    .clk_i                (clk),
    .rstn_i               (rstn),
    .instr_pc_i           (instr_pc),
    .jmp_req_i            (jmp_req),
    .jmp_addr_i           (jmp_addr),
    .illegal_instr_i      (illegal_instr),
    .lsu_new_ctrl_i       (lsu_new_ctrl),
    .lsu_busy_i           (lsu_busy),
    .lsu_err_i            (lsu_err),
    .ifu_get_next_instr_o (get_next),
    .ifu_jmp_instr_o      (jmp_instr),
    .ifu_jmp_address_o    (jmp_address),
    .stall_o              (stall),
    .flush_o              (flush),
    .trap_o               (trap),
    .mepc_o               (mepc),
    .mcause_o             (mcause)
  );

  assign flags = {get_next, jmp_instr, stall, flush, trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    jmp_req       = 1'b0;
    jmp_addr      = 32'h0;
    illegal_instr = 1'b0;
    lsu_new_ctrl  = 1'b0;
    lsu_busy      = 1'b0;
    lsu_err       = 1'b0;
  endtask

  // Two flush cycles then RUN; a jump is offered during flush and must be ignored.
  task automatic flush_to_run(input string tag, input logic [31:0] addr);
    step();
    chk({tag, "_fl0"}, 32'(flags), 32'(F_FLUSH));
    jmp_req  = 1'b1;
    jmp_addr = 32'h80;
    step();
    clr_in();
    chk({tag, "_fl1"}, 32'(flags), 32'(F_FLUSH));
    chk({tag, "_fladdr"}, jmp_address, addr);
    step();
    chk({tag, "_run"}, 32'(flags), 32'(F_RUN));
  endtask

  task automatic boot_seq(input string tag);
    rstn = 1'b1;
    step();
    chk({tag, "_boot"}, 32'(flags), 32'(F_REDIR));
    chk({tag, "_bootaddr"}, jmp_address, 32'h0);
    flush_to_run(tag, 32'h0);
  endtask

  initial begin
    rstn     = 1'b0;
    instr_pc = 32'h0;
    clr_in();

    // Reset held low over two edges
    step();
    step();
    chk("rst_flags", 32'(flags), 32'(F_RST));
    chk("rst_addr", jmp_address, 32'h0);
    chk("rst_mepc", mepc, 32'h0);
    chk("rst_mcause", 32'(mcause), 32'h0);
    boot_seq("rel");

    // Aligned jump
    jmp_req = 1'b1; jmp_addr = 32'h40;
    step();
    clr_in();
    chk("jmp_flags", 32'(flags), 32'(F_REDIR));
    chk("jmp_addr", jmp_address, 32'h40);
    flush_to_run("jmp", 32'h40);

    // Illegal beats jump
    illegal_instr = 1'b1; jmp_req = 1'b1; jmp_addr = 32'h40; instr_pc = 32'h1C;
    step();
    clr_in();
    chk("ill_flags", 32'(flags), 32'(F_TRAP));
    chk("ill_addr", jmp_address, 32'h100);
    chk("ill_mepc", mepc, 32'h1C);
    chk("ill_mcause", 32'(mcause), 32'd2);
    flush_to_run("ill", 32'h100);
    chk("ill_hold_mepc", mepc, 32'h1C);

    // Misaligned target
    jmp_req = 1'b1; jmp_addr = 32'h42; instr_pc = 32'h20;
    step();
    clr_in();
    chk("mis_flags", 32'(flags), 32'(F_TRAP));
    chk("mis_addr", jmp_address, 32'h100);
    chk("mis_mepc", mepc, 32'h20);
    chk("mis_mcause", 32'(mcause), 32'd0);
    flush_to_run("mis", 32'h100);

    // Aligned jump beats load/store
    jmp_req = 1'b1; jmp_addr = 32'h60; lsu_new_ctrl = 1'b1; instr_pc = 32'h24;
    step();
    clr_in();
    chk("jls_flags", 32'(flags), 32'(F_REDIR));
    chk("jls_addr", jmp_address, 32'h60);
    flush_to_run("jls", 32'h60);

    // LSU stall, busy for three cycles
    lsu_new_ctrl = 1'b1; lsu_busy = 1'b1; instr_pc = 32'h30;
    step();
    lsu_new_ctrl = 1'b0; instr_pc = 32'h34;
    chk("lsu_w0", 32'(flags), 32'(F_LSU));
    step();
    chk("lsu_w1", 32'(flags), 32'(F_LSU));
    step();
    chk("lsu_w2", 32'(flags), 32'(F_LSU));
    lsu_busy = 1'b0;
    step();
    chk("lsu_run", 32'(flags), 32'(F_RUN));

    // LSU error takes priority over busy
    lsu_new_ctrl = 1'b1; lsu_busy = 1'b1; instr_pc = 32'h30;
    step();
    lsu_new_ctrl = 1'b0; instr_pc = 32'h34;
    chk("err_w0", 32'(flags), 32'(F_LSU));
    lsu_err = 1'b1;
    step();
    clr_in();
    chk("err_flags", 32'(flags), 32'(F_TRAP));
    chk("err_addr", jmp_address, 32'h100);
    chk("err_mepc", mepc, 32'h30);
    chk("err_mcause", 32'(mcause), 32'd5);
    flush_to_run("err", 32'h100);

    // Reset during LSU_WAIT
    lsu_new_ctrl = 1'b1; lsu_busy = 1'b1; instr_pc = 32'h44;
    step();
    lsu_new_ctrl = 1'b0;
    chk("rl_wait", 32'(flags), 32'(F_LSU));
    rstn = 1'b0;
    step();
    clr_in();
    chk("rl_flags", 32'(flags), 32'(F_RST));
    chk("rl_mepc", mepc, 32'h0);
    chk("rl_mcause", 32'(mcause), 32'h0);
    chk("rl_addr", jmp_address, 32'h0);
    boot_seq("rl");

    // Reset during FLUSH
    jmp_req = 1'b1; jmp_addr = 32'h40;
    step();
    clr_in();
    chk("rf_jmp", 32'(flags), 32'(F_REDIR));
    step();
    chk("rf_fl", 32'(flags), 32'(F_FLUSH));
    rstn = 1'b0;
    step();
    chk("rf_flags", 32'(flags), 32'(F_RST));
    chk("rf_addr", jmp_address, 32'h0);
    boot_seq("rf");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jedro_1_ctrl.md
Name: jedro_1_ctrl

Overview:
Central control FSM for the jedro_1 core. It sequences the IFU (next-instruction requests, jumps, boot and trap redirects). It stalls the decode/execute path while the LSU is busy and flushes fetched instructions after redirects. It also captures trap cause and PC for the future CSR block. It sits between the decoder, ALU and LSU status outputs and the IFU's get_next_instr_i, jmp_instr_i and jmp_address_i inputs, which are currently tied off in jedro_1_top.

Parameters:
DATA_WIDTH, 32, width of addresses and PC.
BOOT_ADDR, 32'h0000_0000, first fetch address after reset.
TRAP_VEC, 32'h0000_0100, redirect address on any trap.
FLUSH_CYCLES, 2, instructions discarded after a redirect (IFU+decoder depth); legal range 1..15.

Ports:
clk_i  in  1  core clock
rstn_i  in  1  reset; synchronous, active-low
instr_pc_i  in  DATA_WIDTH  PC of the instruction currently in decode
jmp_req_i  in  1  resolved taken jump/branch, valid one cycle
jmp_addr_i  in  DATA_WIDTH  target for jmp_req_i
illegal_instr_i  in  1  decoder illegal-instruction flag
lsu_new_ctrl_i  in  1  decoder issued a load/store this cycle
lsu_busy_i  in  1  LSU transaction in progress
lsu_err_i  in  1  LSU access fault, one-cycle pulse
ifu_get_next_instr_o  out  1  IFU advance
ifu_jmp_instr_o  out  1  IFU redirect strobe, one cycle
ifu_jmp_address_o  out  DATA_WIDTH  redirect target
stall_o  out  1  freeze decoder/regfile/ALU state
flush_o  out  1  treat decoded instruction as bubble (no writeback)
trap_o  out  1  trap taken, one cycle
mepc_o  out  DATA_WIDTH  captured trap PC
mcause_o  out  4  captured trap cause

Behaviour:
- States: BOOT, FLUSH, RUN, JUMP, LSU_WAIT, TRAP. All outputs are registered or decoded from state only (Moore). No input reaches an output combinationally.
- Reset (rstn_i=0 at a clk_i edge, from any state, including mid-LSU or mid-flush):
  - next state BOOT; flush counter cleared; mepc_o=0; mcause_o=0; ifu_jmp_address_o=BOOT_ADDR.
  - While rstn_i stays low: ifu_get_next_instr_o=0, ifu_jmp_instr_o=0, stall_o=1, flush_o=1, trap_o=0.
- Output decode:
  - stall_o = (state!=RUN).
  - flush_o = state in {BOOT, JUMP, TRAP, FLUSH}.
  - ifu_get_next_instr_o = state in {RUN, FLUSH}.
  - ifu_jmp_instr_o = state in {BOOT, JUMP, TRAP}.
  - trap_o = (state==TRAP).
- BOOT: one cycle, after reset release. Redirects to BOOT_ADDR, then goes to FLUSH.
- JUMP: one cycle. Redirects to the target registered in RUN, then goes to FLUSH.
- TRAP: one cycle. Redirects to TRAP_VEC, then goes to FLUSH.
- FLUSH:
  - On entry the counter loads FLUSH_CYCLES-1 and decrements each cycle. At 0 the next state is RUN.
  - FLUSH therefore lasts exactly FLUSH_CYCLES cycles.
  - All event inputs are ignored in FLUSH, JUMP, TRAP and BOOT.
- RUN: evaluates inputs every cycle. Fixed priority; only the highest event acts:
  1. illegal_instr_i: TRAP; mepc<=instr_pc_i; mcause<=2.
  2. jmp_req_i with jmp_addr_i[1:0]!=0: TRAP; mepc<=instr_pc_i; mcause<=0 (misaligned).
  3. jmp_req_i aligned: JUMP; target register<=jmp_addr_i.
  4. lsu_new_ctrl_i: LSU_WAIT; pending-PC register<=instr_pc_i.
  5. otherwise: stay in RUN.
- Redirect latency: an event sampled at edge N produces ifu_jmp_instr_o=1 during cycle N+1. The first non-flushed instruction follows FLUSH_CYCLES cycles later.
- LSU_WAIT:
  - Minimum one cycle.
  - lsu_err_i=1: TRAP; mepc<=pending PC; mcause<=5. Error takes priority over busy.
  - else lsu_busy_i=0: RUN.
  - else: stay in LSU_WAIT.
- mepc_o and mcause_o hold their values until the next trap or reset.
- Illegal-state recovery: an unreachable state encoding goes to BOOT.

Decomposition:
- Add to the shared jedro_1_defines package:
  - ctrl_state_e enum.
  - MCAUSE_INSTR_MISALIGN=4'd0, MCAUSE_ILLEGAL_INSTR=4'd2, MCAUSE_LOAD_FAULT=4'd5.
  - Default BOOT_ADDR and TRAP_VEC constants.
- No sub-module: the flush counter and capture registers stay inline (about 200 lines).

Test Plan:
- Reset release: rstn_i 0→1 → one cycle ifu_jmp_instr_o=1 with address 0x0, then flush_o=1 for 2 cycles, then RUN with stall_o=0 and get_next=1.
- Jump: in RUN, jmp_req_i=1, jmp_addr_i=0x40 → next cycle ifu_jmp_instr_o=1 with address 0x40, then 2 flush cycles, then RUN.
- Priority and misaligned target:
  - illegal_instr_i=1 together with jmp_req_i (0x40), instr_pc_i=0x1C → trap_o=1, redirect to 0x100, mepc_o=0x1C, mcause_o=2; no 0x40 redirect.
  - jmp_addr_i=0x42 alone → mcause_o=0.
- LSU stall: lsu_new_ctrl_i at PC 0x30, lsu_busy_i high 3 cycles → stall_o=1 and get_next=0 for those cycles; RUN the cycle after busy drops.
- LSU error: lsu_err_i during LSU_WAIT → TRAP, mepc_o=0x30, mcause_o=5.
- Reset mid-operation: rstn_i=0 during LSU_WAIT or FLUSH → next edge BOOT with reset output values and mepc_o/mcause_o cleared; recovery as in the reset-release case.
